// File: rtl/proc_mem_arbiter_if.sv
// Request/response bus bundle shared by the fetch, data and memory ports.
// master drives req_*/resp_rdy; slave drives req_rdy/resp_val/resp_data.
interface proc_mem_arbiter_if #(
    parameter int p_data_bits = 32
);
    logic                   req_val;
    logic                   req_rdy;
    logic                   req_op;
    logic [p_data_bits-1:0] req_addr;
    logic [p_data_bits-1:0] req_wdata;
    logic                   resp_val;
    logic                   resp_rdy;
    logic [p_data_bits-1:0] resp_data;

    modport master (
        output req_val, req_op, req_addr, req_wdata, resp_rdy,
        input  req_rdy, resp_val, resp_data
    );

    modport slave (
        input  req_val, req_op, req_addr, req_wdata, resp_rdy,
        output req_rdy, resp_val, resp_data
    );
endinterface

// File: rtl/proc_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data.
// Ports: clk, rst (async high), imem/dmem slave buses, mem master bus,
// inflight_count = number of outstanding memory requests.
module proc_mem_arbiter #(
    parameter int p_num_inflight = 4,
    parameter int p_data_bits    = 32,
    localparam int CW = $clog2(p_num_inflight) + 1,
    localparam int PW = $clog2(p_num_inflight)
) (
    input  logic                       clk,
    input  logic                       rst,
    proc_mem_arbiter_if.slave          imem,
    proc_mem_arbiter_if.slave          dmem,
    proc_mem_arbiter_if.master         mem,
    output logic [CW-1:0]              inflight_count
);
    logic                      prio_q, prio_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic [p_num_inflight-1:0] tags_q, tags_d;

    logic full, empty, gnt_dmem, push, pop, owner;

    // Fetch is always a read; its op/wdata fields are deliberately ignored.
    logic unused_imem;
    assign unused_imem = ^{imem.req_op, imem.req_wdata};

    always_comb begin
        full  = (count_q == CW'(p_num_inflight));
        empty = (count_q == '0);

        // dmem wins when it is the only requester or holds priority.
        gnt_dmem = dmem.req_val & (!imem.req_val | prio_q);

        mem.req_val   = !rst & !full &
                        (gnt_dmem ? dmem.req_val : imem.req_val);
        mem.req_op    = gnt_dmem ? dmem.req_op    : 1'b0;
        mem.req_addr  = gnt_dmem ? dmem.req_addr  : imem.req_addr;
        mem.req_wdata = gnt_dmem ? dmem.req_wdata : '0;

        imem.req_rdy = !rst & !full & !gnt_dmem & mem.req_rdy;
        dmem.req_rdy = !rst & !full &  gnt_dmem & mem.req_rdy;

        push = mem.req_val & mem.req_rdy;

        owner          = tags_q[rd_ptr_q];
        imem.resp_val  = !rst & !empty & !owner & mem.resp_val;
        dmem.resp_val  = !rst & !empty &  owner & mem.resp_val;
        mem.resp_rdy   = !rst & !empty &
                         (owner ? dmem.resp_rdy : imem.resp_rdy);
        imem.resp_data = mem.resp_data;
        dmem.resp_data = mem.resp_data;

        pop = mem.resp_val & mem.resp_rdy;

        tags_d = tags_q;
        if (push) tags_d[wr_ptr_q] = gnt_dmem;
        prio_d   = push ? !gnt_dmem : prio_q;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);

        inflight_count = count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tags_q   <= '0;
        end else begin
            prio_q   <= prio_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tags_q   <= tags_d;
        end
    end
endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Directed bench for proc_mem_arbiter: fetch, contention, full,
// ordering, backpressure and mid-operation reset.
module tb_proc_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] inflight_count;

    always #5 clk = ~clk;

    proc_mem_arbiter_if #(.p_data_bits(32)) imem_if ();
    proc_mem_arbiter_if #(.p_data_bits(32)) dmem_if ();
    proc_mem_arbiter_if #(.p_data_bits(32)) mem_if ();

    proc_mem_arbiter #(
        .p_num_inflight(4),
        .p_data_bits(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem(imem_if),
        .dmem(dmem_if),
        .mem(mem_if),
        .inflight_count(inflight_count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        imem_if.req_val   = 1'b0;
        imem_if.req_op    = 1'b0;
        imem_if.req_addr  = '0;
        imem_if.req_wdata = '0;
        imem_if.resp_rdy  = 1'b1;
        dmem_if.req_val   = 1'b0;
        dmem_if.req_op    = 1'b0;
        dmem_if.req_addr  = '0;
        dmem_if.req_wdata = '0;
        dmem_if.resp_rdy  = 1'b1;
        mem_if.req_rdy    = 1'b1;
        mem_if.resp_val   = 1'b0;
        mem_if.resp_data  = '0;
    endtask

    task automatic reset_pulse();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
    endtask

    logic exp_own [4];
    logic ord_own [3];

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        chk("rst_count", 32'(inflight_count), 0);
        chk("rst_mem_req_val", 32'(mem_if.req_val), 0);
        chk("rst_imem_rdy", 32'(imem_if.req_rdy), 0);
        rst = 1'b0;
        settle();

        // Single fetch; imem op/wdata must be forced to read / zero.
        imem_if.req_val   = 1'b1;
        imem_if.req_addr  = 32'h200;
        imem_if.req_op    = 1'b1;
        imem_if.req_wdata = 32'hFFFF;
        settle();
        chk("fetch_req_val", 32'(mem_if.req_val), 1);
        chk("fetch_addr", mem_if.req_addr, 32'h200);
        chk("fetch_op", 32'(mem_if.req_op), 0);
        chk("fetch_wdata", mem_if.req_wdata, 0);
        chk("fetch_rdy", 32'(imem_if.req_rdy), 1);
        chk("fetch_dmem_rdy", 32'(dmem_if.req_rdy), 0);
        tick();
        idle_inputs();
        settle();
        chk("fetch_count1", 32'(inflight_count), 1);
        mem_if.resp_val  = 1'b1;
        mem_if.resp_data = 32'h13;
        settle();
        chk("fetch_resp_val", 32'(imem_if.resp_val), 1);
        chk("fetch_resp_data", imem_if.resp_data, 32'h13);
        chk("fetch_dmem_resp_val", 32'(dmem_if.resp_val), 0);
        chk("fetch_mem_resp_rdy", 32'(mem_if.resp_rdy), 1);
        tick();
        mem_if.resp_val = 1'b0;
        settle();
        chk("fetch_count0", 32'(inflight_count), 0);

        // Contention from reset: imem, dmem, imem, dmem until full.
        reset_pulse();
        imem_if.req_val  = 1'b1;
        imem_if.req_addr = 32'h200;
        dmem_if.req_val  = 1'b1;
        dmem_if.req_addr = 32'h1000;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("cont_addr", mem_if.req_addr,
                (i % 2 == 0) ? 32'h200 : 32'h1000);
            chk("cont_imem_rdy", 32'(imem_if.req_rdy),
                (i % 2 == 0) ? 1 : 0);
            tick();
        end
        settle();
        chk("full_count", 32'(inflight_count), 4);
        chk("full_req_val", 32'(mem_if.req_val), 0);
        chk("full_imem_rdy", 32'(imem_if.req_rdy), 0);
        chk("full_dmem_rdy", 32'(dmem_if.req_rdy), 0);

        // A pop while full does not allow a push in the same cycle.
        mem_if.resp_val  = 1'b1;
        mem_if.resp_data = 32'hA;
        settle();
        chk("full_pop_resp", 32'(imem_if.resp_val), 1);
        chk("full_pop_data", imem_if.resp_data, 32'hA);
        chk("full_pop_req_val", 32'(mem_if.req_val), 0);
        chk("full_pop_imem_rdy", 32'(imem_if.req_rdy), 0);
        tick();
        mem_if.resp_val = 1'b0;
        settle();
        chk("after_pop_count", 32'(inflight_count), 3);
        chk("after_pop_req_val", 32'(mem_if.req_val), 1);
        chk("after_pop_addr", mem_if.req_addr, 32'h200);
        tick();
        imem_if.req_val = 1'b0;
        dmem_if.req_val = 1'b0;
        settle();
        chk("refill_count", 32'(inflight_count), 4);

        // Drain across the wrapped pointers: dmem, imem, dmem, imem.
        exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            mem_if.resp_val  = 1'b1;
            mem_if.resp_data = 32'h100 + 32'(i);
            settle();
            chk("drain_imem_val", 32'(imem_if.resp_val),
                exp_own[i] ? 0 : 1);
            chk("drain_dmem_val", 32'(dmem_if.resp_val),
                exp_own[i] ? 1 : 0);
            chk("drain_data", dmem_if.resp_data, 32'h100 + 32'(i));
            tick();
        end
        settle();
        chk("drain_count", 32'(inflight_count), 0);
        chk("empty_resp_rdy", 32'(mem_if.resp_rdy), 0);
        chk("empty_imem_val", 32'(imem_if.resp_val), 0);
        mem_if.resp_val = 1'b0;

        // Ordering: imem 0x200, dmem lw 0x1000, imem 0x204.
        reset_pulse();
        imem_if.req_val  = 1'b1;
        imem_if.req_addr = 32'h200;
        tick();
        imem_if.req_val  = 1'b0;
        dmem_if.req_val  = 1'b1;
        dmem_if.req_op   = 1'b0;
        dmem_if.req_addr = 32'h1000;
        settle();
        chk("ord_lw_addr", mem_if.req_addr, 32'h1000);
        chk("ord_lw_op", 32'(mem_if.req_op), 0);
        tick();
        dmem_if.req_val  = 1'b0;
        imem_if.req_val  = 1'b1;
        imem_if.req_addr = 32'h204;
        tick();
        imem_if.req_val = 1'b0;
        settle();
        chk("ord_count", 32'(inflight_count), 3);
        ord_own = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            mem_if.resp_val  = 1'b1;
            mem_if.resp_data = 32'hA + 32'(i);
            settle();
            chk("ord_imem_val", 32'(imem_if.resp_val),
                ord_own[i] ? 0 : 1);
            chk("ord_dmem_val", 32'(dmem_if.resp_val),
                ord_own[i] ? 1 : 0);
            chk("ord_data", imem_if.resp_data, 32'hA + 32'(i));
            tick();
        end
        mem_if.resp_val = 1'b0;
        settle();
        chk("ord_count0", 32'(inflight_count), 0);

        // Backpressure on a dmem store response.
        dmem_if.req_val   = 1'b1;
        dmem_if.req_op    = 1'b1;
        dmem_if.req_addr  = 32'h2000;
        dmem_if.req_wdata = 32'h55;
        settle();
        chk("sw_op", 32'(mem_if.req_op), 1);
        chk("sw_wdata", mem_if.req_wdata, 32'h55);
        tick();
        dmem_if.req_val  = 1'b0;
        dmem_if.resp_rdy = 1'b0;
        mem_if.resp_val  = 1'b1;
        mem_if.resp_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_mem_resp_rdy", 32'(mem_if.resp_rdy), 0);
            chk("bp_dmem_val", 32'(dmem_if.resp_val), 1);
            tick();
            chk("bp_count", 32'(inflight_count), 1);
        end
        dmem_if.resp_rdy = 1'b1;
        settle();
        chk("bp_release_rdy", 32'(mem_if.resp_rdy), 1);
        chk("bp_release_data", dmem_if.resp_data, 32'hDEADBEEF);
        tick();
        mem_if.resp_val = 1'b0;
        settle();
        chk("bp_count0", 32'(inflight_count), 0);
        chk("bp_once", 32'(dmem_if.resp_val), 0);

        // Reset with three requests in flight.
        imem_if.req_val  = 1'b1;
        imem_if.req_addr = 32'h300;
        dmem_if.req_op   = 1'b0;
        dmem_if.req_addr = 32'h1000;
        tick();
        tick();
        tick();
        settle();
        chk("mid_count3", 32'(inflight_count), 3);
        mem_if.resp_val = 1'b1;
        rst = 1'b1;
        settle();
        chk("mid_rst_count", 32'(inflight_count), 0);
        chk("mid_rst_req_val", 32'(mem_if.req_val), 0);
        chk("mid_rst_imem_resp", 32'(imem_if.resp_val), 0);
        chk("mid_rst_imem_rdy", 32'(imem_if.req_rdy), 0);
        tick();
        rst = 1'b0;
        mem_if.resp_val  = 1'b0;
        imem_if.req_addr = 32'h200;
        dmem_if.req_val  = 1'b1;
        settle();
        chk("mid_first_grant", mem_if.req_addr, 32'h200);
        chk("mid_first_rdy", 32'(imem_if.req_rdy), 1);
        tick();
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
